// File: rtl/branch_target_buffer_if.sv
// Lookup/update/statistics bundle between the fetch stage and the branch target buffer.
interface branch_target_buffer_if #(
  parameter int unsigned PC_W   = 32,
  parameter int unsigned STAT_W = 16
);
  logic              lk_valid;
  logic [PC_W-1:0]   lk_pc;
  logic              pred_hit;
  logic              pred_taken;
  logic [PC_W-1:0]   pred_target;
  logic              upd_valid;
  logic [PC_W-1:0]   upd_pc;
  logic              upd_taken;
  logic              upd_is_jump;
  logic [PC_W-1:0]   upd_target;
  logic              flush;
  logic              stat_clr;
  logic [STAT_W-1:0] stat_lookups;
  logic [STAT_W-1:0] stat_hits;

  modport master (
    output lk_valid, lk_pc, upd_valid, upd_pc, upd_taken, upd_is_jump, upd_target,
           flush, stat_clr,
    input  pred_hit, pred_taken, pred_target, stat_lookups, stat_hits
  );

  modport slave (
    input  lk_valid, lk_pc, upd_valid, upd_pc, upd_taken, upd_is_jump, upd_target,
           flush, stat_clr,
    output pred_hit, pred_taken, pred_target, stat_lookups, stat_hits
  );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Zero-latency lookup from registered state; updates land on the rising edge.
module branch_target_buffer #(
  parameter int unsigned PC_W    = 32,
  parameter int unsigned PC_LSB  = 2,
  parameter int unsigned INDEX_W = 6,
  parameter int unsigned CTR_W   = 2,
  parameter int unsigned STAT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  branch_target_buffer_if.slave bus
);
  localparam int unsigned ENTRIES = 1 << INDEX_W;
  localparam int unsigned TAG_W   = PC_W - PC_LSB - INDEX_W;
  localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1) << (CTR_W - 1);
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_WT - CTR_W'(1);
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

  logic             validQ  [ENTRIES];
  logic [TAG_W-1:0] tagQ    [ENTRIES];
  logic [PC_W-1:0]  targetQ [ENTRIES];
  logic [CTR_W-1:0] ctrQ    [ENTRIES];

  logic [INDEX_W-1:0] lkIdx;
  logic [TAG_W-1:0]   lkTag;
  logic               lkHit;
  logic [INDEX_W-1:0] updIdx;
  logic [TAG_W-1:0]   updTag;
  logic               updHit;
  logic               wrEn;
  logic [CTR_W-1:0]   wrCtr;
  logic [PC_W-1:0]    wrTarget;
  logic [STAT_W-1:0]  statLookupsQ;
  logic [STAT_W-1:0]  statHitsQ;

  assign lkIdx  = bus.lk_pc[PC_LSB +: INDEX_W];
  assign lkTag  = bus.lk_pc[PC_LSB + INDEX_W +: TAG_W];
  assign updIdx = bus.upd_pc[PC_LSB +: INDEX_W];
  assign updTag = bus.upd_pc[PC_LSB + INDEX_W +: TAG_W];

  // Lookup reads pre-update contents; no bypass from a same-cycle update.
  assign lkHit           = bus.lk_valid & validQ[lkIdx] & (tagQ[lkIdx] == lkTag);
  assign bus.pred_hit    = lkHit;
  assign bus.pred_taken  = lkHit & ctrQ[lkIdx][CTR_W-1];
  assign bus.pred_target = lkHit ? targetQ[lkIdx] : '0;

  assign updHit = validQ[updIdx] & (tagQ[updIdx] == updTag);

  // Entry write decision: train on hit, allocate only on a taken miss.
  always_comb begin
    wrEn     = 1'b0;
    wrCtr    = ctrQ[updIdx];
    wrTarget = targetQ[updIdx];
    if (bus.upd_valid) begin
      if (updHit) begin
        wrEn = 1'b1;
        if (bus.upd_is_jump) begin
          wrCtr    = CTR_MAX;
          wrTarget = bus.upd_target;
        end else if (bus.upd_taken) begin
          wrCtr    = (ctrQ[updIdx] == CTR_MAX) ? CTR_MAX : ctrQ[updIdx] + CTR_W'(1);
          wrTarget = bus.upd_target;
        end else begin
          wrCtr    = (ctrQ[updIdx] == '0) ? '0 : ctrQ[updIdx] - CTR_W'(1);
        end
      end else if (bus.upd_taken) begin
        wrEn     = 1'b1;
        wrCtr    = bus.upd_is_jump ? CTR_MAX : CTR_WT;
        wrTarget = bus.upd_target;
      end
    end
  end

  // Flush only drops valid bits and takes priority over any update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        validQ[i]  <= 1'b0;
        tagQ[i]    <= '0;
        targetQ[i] <= '0;
        ctrQ[i]    <= CTR_WNT;
      end
    end else if (bus.flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        validQ[i] <= 1'b0;
      end
    end else if (wrEn) begin
      validQ[updIdx]  <= 1'b1;
      tagQ[updIdx]    <= updTag;
      targetQ[updIdx] <= wrTarget;
      ctrQ[updIdx]    <= wrCtr;
    end
  end

  // Saturating statistics; clear beats increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      statLookupsQ <= '0;
      statHitsQ    <= '0;
    end else if (bus.stat_clr) begin
      statLookupsQ <= '0;
      statHitsQ    <= '0;
    end else begin
      if (bus.lk_valid && statLookupsQ != STAT_MAX) statLookupsQ <= statLookupsQ + STAT_W'(1);
      if (lkHit && statHitsQ != STAT_MAX)           statHitsQ    <= statHitsQ + STAT_W'(1);
    end
  end

  assign bus.stat_lookups = statLookupsQ;
  assign bus.stat_hits    = statHitsQ;
endmodule
